// File: rtl/clock_pkg.sv
// Shared encodings and limits for the alarm clock core: field selects,
// alarm FSM states and the wrap points of each time field.
package clock_pkg;

   localparam logic [2:0] SEL_NONE  = 3'd0;
   localparam logic [2:0] SEL_SEC   = 3'd1;
   localparam logic [2:0] SEL_MIN   = 3'd2;
   localparam logic [2:0] SEL_HOUR  = 3'd3;
   localparam logic [2:0] SEL_AMIN  = 3'd4;
   localparam logic [2:0] SEL_AHOUR = 3'd5;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter: inc and plus count up, minus counts down, both wrap.
// carry flags the MAX->0 wrap caused by inc only, so adjustment never ripples.
module wrap_counter #(
   parameter int MAX   = 59,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             plus,
   input  logic             minus,
   output logic [WIDTH-1:0] cnt,
   output logic             carry
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             up;
   logic             down;

   always_comb begin
      up       = inc | (plus & ~minus);
      down     = ~inc & minus & ~plus;
      cnt_next = cnt_reg;
      if (up) begin
         cnt_next = (cnt_reg == MAX_V) ? '0 : cnt_reg + 1'b1;
      end else if (down) begin
         cnt_next = (cnt_reg == '0) ? MAX_V : cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt   = cnt_reg;
   assign carry = inc & (cnt_reg == MAX_V);

endmodule

// File: rtl/alarm_clock_core.sv
// HH:MM:SS timekeeper with field adjustment, 12/24-hour display conversion
// and an alarm FSM supporting ring timeout and snooze.
module alarm_clock_core
   import clock_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       plus,
   input  logic       minus,
   input  logic [2:0] select,
   input  logic       hour_12,
   input  logic       alarm_en,
   input  logic       stop,
   input  logic       snooze,
   output logic [5:0] hours,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic [5:0] disp_hours,
   output logic       pm,
   output logic [5:0] alarm_hours,
   output logic [5:0] alarm_mins,
   output logic       ringing,
   output logic       snoozing
);

   localparam int DIV_W     = $clog2(CLK_HZ);
   localparam int SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
   localparam logic [7:0]       RING_V   = 8'(RING_SEC);
   localparam logic [SNZ_W-1:0] SNZ_V    = SNZ_W'(SNZ_TICKS);

   // Field order: secs, mins, hours, alarm mins, alarm hours.
   localparam logic [14:0] FIELD_SEL = {SEL_AHOUR, SEL_AMIN, SEL_HOUR, SEL_MIN, SEL_SEC};

   logic [DIV_W-1:0] div_reg;
   logic             adjust;
   logic             sec_tick;
   logic [4:0]       field_hit;
   logic [4:0]       fld_plus;
   logic [4:0]       fld_minus;
   logic             sec_carry;
   logic             min_carry;
   logic [2:0]       unused_carry;
   logic             tick_wrap_reg;
   logic             match;

   alarm_state_t     state_reg;
   alarm_state_t     state_next;
   logic [7:0]       ring_cnt_reg;
   logic [7:0]       ring_cnt_next;
   logic [SNZ_W-1:0] snz_cnt_reg;
   logic [SNZ_W-1:0] snz_cnt_next;

   // Any adjust pulse restarts the second so the edited value holds a full second.
   assign adjust   = plus | minus;
   assign sec_tick = enable & ~adjust & (div_reg == DIV_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_reg <= '0;
      end else if (adjust) begin
         div_reg <= '0;
      end else if (enable) begin
         div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_field
         assign field_hit[gi] = (select == FIELD_SEL[gi*3 +: 3]);
         assign fld_plus[gi]  = plus  & field_hit[gi];
         assign fld_minus[gi] = minus & field_hit[gi];
      end
   endgenerate

   wrap_counter #(.MAX(SEC_MAX), .WIDTH(6)) u_secs (
      .clk(clk), .reset_n(reset_n), .inc(sec_tick),
      .plus(fld_plus[0]), .minus(fld_minus[0]), .cnt(secs), .carry(sec_carry)
   );

   wrap_counter #(.MAX(MIN_MAX), .WIDTH(6)) u_mins (
      .clk(clk), .reset_n(reset_n), .inc(sec_carry),
      .plus(fld_plus[1]), .minus(fld_minus[1]), .cnt(mins), .carry(min_carry)
   );

   wrap_counter #(.MAX(HOUR_MAX), .WIDTH(6)) u_hours (
      .clk(clk), .reset_n(reset_n), .inc(min_carry),
      .plus(fld_plus[2]), .minus(fld_minus[2]), .cnt(hours), .carry(unused_carry[0])
   );

   wrap_counter #(.MAX(MIN_MAX), .WIDTH(6)) u_alarm_mins (
      .clk(clk), .reset_n(reset_n), .inc(1'b0),
      .plus(fld_plus[3]), .minus(fld_minus[3]), .cnt(alarm_mins), .carry(unused_carry[1])
   );

   wrap_counter #(.MAX(HOUR_MAX), .WIDTH(6)) u_alarm_hours (
      .clk(clk), .reset_n(reset_n), .inc(1'b0),
      .plus(fld_plus[4]), .minus(fld_minus[4]), .cnt(alarm_hours), .carry(unused_carry[2])
   );

   // Remember that the last edge rolled secs to 0 by ticking; compare against
   // the freshly updated counters so adjusted-in values never match.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_wrap_reg <= 1'b0;
      end else begin
         tick_wrap_reg <= sec_tick & sec_carry;
      end
   end

   assign match = tick_wrap_reg & (hours == alarm_hours) & (mins == alarm_mins);

   always_comb begin
      state_next    = state_reg;
      ring_cnt_next = ring_cnt_reg;
      snz_cnt_next  = snz_cnt_reg;
      if (!alarm_en) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (match) begin
                  state_next    = RINGING;
                  ring_cnt_next = RING_V;
               end
            end
            RINGING: begin
               if (stop) begin
                  state_next = IDLE;
               end else if (snooze) begin
                  state_next   = SNOOZE;
                  snz_cnt_next = SNZ_V;
               end else if (sec_tick) begin
                  ring_cnt_next = ring_cnt_reg - 1'b1;
                  if (ring_cnt_reg <= 8'd1) begin
                     state_next = IDLE;
                  end
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_next = IDLE;
               end else if (sec_tick) begin
                  snz_cnt_next = snz_cnt_reg - 1'b1;
                  if (snz_cnt_reg <= SNZ_W'(1)) begin
                     state_next    = RINGING;
                     ring_cnt_next = RING_V;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         ring_cnt_reg <= '0;
         snz_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         ring_cnt_reg <= ring_cnt_next;
         snz_cnt_reg  <= snz_cnt_next;
      end
   end

   assign ringing  = (state_reg == RINGING);
   assign snoozing = (state_reg == SNOOZE);

   always_comb begin
      disp_hours = hours;
      if (hour_12) begin
         if (hours == 6'd0) begin
            disp_hours = 6'd12;
         end else if (hours > 6'd12) begin
            disp_hours = hours - 6'd12;
         end
      end
   end

   assign pm = (hours >= 6'd12);

endmodule
